chan_pkt_buffer: RTL

Per-channel TX packet buffer that feeds the channel FIFO reader. It takes 32-bit words from the USB packet writer and stores them in fixed 128-word packet slots. It presents the current packet in show-ahead form: header on fifodata before any read, plus pkt_waiting. It advances one word per rdreq and releases the whole slot on skip.

---
 rtl/chan_pkt_buffer_if.sv | 21 ++
 rtl/chan_pkt_buffer.sv | 63 ++++++
 2 files changed

// File: rtl/chan_pkt_buffer_if.sv
// chan_pkt_buffer_if: write, read and status signals of the per-channel TX packet buffer
interface chan_pkt_buffer_if #(parameter int CNT_W = 3);
  logic             clear;
  logic             wrreq;
  logic [31:0]      wrdata;
  logic             have_space;
  logic             overflow;
  logic [31:0]      fifodata;
  logic             pkt_waiting;
  logic             rdreq;
  logic             skip;
  logic [CNT_W-1:0] packets;
  modport master (
    output clear, wrreq, wrdata, rdreq, skip,
    input  have_space, overflow, fifodata, pkt_waiting, packets
  );
  modport slave (
    input  clear, wrreq, wrdata, rdreq, skip,
    output have_space, overflow, fifodata, pkt_waiting, packets
  );
endinterface

// File: rtl/chan_pkt_buffer.sv
// chan_pkt_buffer: slot-based TX packet buffer with show-ahead read and whole-packet release
module chan_pkt_buffer #(
  parameter int PKT_WORDS = 128,
  parameter int NUM_PKTS  = 4,
  parameter int CNT_W     = 3
) (
  input logic              tx_clock,
  input logic              reset,
  chan_pkt_buffer_if.slave bus
);
  localparam int OFF_W  = $clog2(PKT_WORDS);
  localparam int SLOT_W = $clog2(NUM_PKTS);
  logic [31:0]       ram [NUM_PKTS*PKT_WORDS];
  logic [SLOT_W-1:0] wr_slot, rd_slot;
  logic [OFF_W-1:0]  wr_off, rd_off;
  logic [CNT_W-1:0]  packets;
  logic              overflow;
  logic              flush, have_space, any_pkt, wr_ok, commit, skip_ok, rd_ok;
  assign flush      = reset | bus.clear;
  assign have_space = packets != CNT_W'(NUM_PKTS);
  assign any_pkt    = packets != '0;
  assign wr_ok      = bus.wrreq & have_space;
  // the slot is complete when its last offset is written; offsets are a power of two
  assign commit     = wr_ok & (&wr_off);
  assign skip_ok    = bus.skip & any_pkt;
  assign rd_ok      = bus.rdreq & ~bus.skip & any_pkt;
  // store accepted words; contents survive reset and clear
  always_ff @(posedge tx_clock)
    if (wr_ok && !flush) ram[{wr_slot, wr_off}] <= bus.wrdata;
  // write pointer walks the slot and moves to the next slot on commit
  always_ff @(posedge tx_clock)
    if (flush) begin
      wr_slot <= '0;
      wr_off  <= '0;
    end else if (wr_ok) begin
      wr_off <= wr_off + 1'b1;
      if (commit) wr_slot <= wr_slot + 1'b1;
    end
  // read pointer: skip releases the slot, rdreq steps within it and wraps inside the slot
  always_ff @(posedge tx_clock)
    if (flush) begin
      rd_slot <= '0;
      rd_off  <= '0;
    end else if (skip_ok) begin
      rd_slot <= rd_slot + 1'b1;
      rd_off  <= '0;
    end else if (rd_ok) rd_off <= rd_off + 1'b1;
  // complete-packet count; a commit and a release in the same cycle cancel
  always_ff @(posedge tx_clock)
    if (flush) packets <= '0;
    else if (commit && !skip_ok) packets <= packets + 1'b1;
    else if (skip_ok && !commit) packets <= packets - 1'b1;
  // sticky overflow survives clear, only reset drops it
  always_ff @(posedge tx_clock)
    if (reset) overflow <= 1'b0;
    else if (bus.wrreq && !have_space && !bus.clear) overflow <= 1'b1;
  assign bus.have_space  = have_space;
  assign bus.overflow    = overflow;
  assign bus.packets     = packets;
  assign bus.fifodata    = ram[{rd_slot, rd_off}];
  // the packet being released this cycle is not reported as waiting
  assign bus.pkt_waiting = bus.skip ? (packets >= CNT_W'(2)) : any_pkt;
endmodule
